// File: rtl/controller_pkg.sv
// Shared encodings for the main controller: display modes, UART command
// bytes and the acknowledge transmitter state machine.
package controller_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_WATCH     = 2'd0,
    MODE_STOPWATCH = 2'd1,
    MODE_SENS_A    = 2'd2,
    MODE_SENS_B    = 2'd3
  } mode_e;

  localparam logic [7:0] CMD_MODE_NEXT = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_MODE_HOME = 8'h57;  // 'W'
  localparam logic [7:0] ASCII_ZERO    = 8'h30;  // '0'

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2
  } tx_state_e;

  // Last LAUNCH cycle index before giving up on tx_busy (4 cycles total)
  localparam logic [1:0] LAUNCH_LAST = 2'd3;

  // ASCII digit reporting a mode in the acknowledge stream
  function automatic logic [7:0] mode_ascii(input mode_e m);
    return ASCII_ZERO + {6'd0, m};
  endfunction

endpackage

// File: rtl/ack_fifo.sv
// Small synchronous FIFO for acknowledge bytes. The head entry is visible
// combinationally; a push and a pop may happen in the same cycle, also when full.
module ack_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push_ok;
  logic              pop_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so the count MSB alone marks full
  assign full  = count[PTR_W];
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Shares the UART RX byte stream between the per-mode decoders, consumes
// mode-change commands, and returns one acknowledge byte per received byte
// through the UART TX core.
module uart_cmd_dispatcher
  import controller_pkg::*;
#(
  parameter int N_MODE    = 4,
  parameter int ACK_DEPTH = 4,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              btn_mode,
  input  logic              tx_busy,
  output logic [1:0]        o_mode,
  output logic [N_MODE-1:0] o_sel,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_done,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              o_ack_ovf
);

  function automatic logic [N_MODE-1:0] sel_onehot(input mode_e m);
    logic [N_MODE-1:0] s;
    s    = '0;
    s[m] = 1'b1;
    return s;
  endfunction

  mode_e             mode_q;
  mode_e             mode_nxt;
  logic              is_next;
  logic              is_home;
  logic              is_cmd;
  logic              fwd;

  logic [DATA_W-1:0] fwd_data_p1;
  logic [N_MODE-1:0] fwd_sel_p1;
  logic              vld_p1;

  logic              ack_push;
  logic [DATA_W-1:0] ack_data;
  logic              ack_pop;
  logic [DATA_W-1:0] ack_head;
  logic              ack_full;
  logic              ack_empty;
  logic              ovf_q;

  tx_state_e         state_q;
  tx_state_e         state_nxt;
  logic [1:0]        lcnt_q;
  logic [1:0]        lcnt_nxt;

  assign is_next = rx_done && (rx_data == CMD_MODE_NEXT);
  assign is_home = rx_done && (rx_data == CMD_MODE_HOME);
  assign is_cmd  = is_next || is_home;
  assign fwd     = rx_done && !is_cmd;

  // Next mode: 'W' overrides everything; 'M' and the button together step once
  always_comb begin
    mode_nxt = mode_q;
    if (is_home) begin
      mode_nxt = MODE_WATCH;
    end else if (is_next || btn_mode) begin
      mode_nxt = mode_e'(mode_q + 1'b1);
    end
  end

  // Live display mode register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_q <= MODE_WATCH;
    else      mode_q <= mode_nxt;
  end

  // Stage p0 -> p1: forward non-command bytes with the select of the pre-update mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      fwd_data_p1 <= '0;
      fwd_sel_p1  <= sel_onehot(MODE_WATCH);
    end else begin
      vld_p1 <= fwd;
      if (fwd) begin
        fwd_data_p1 <= rx_data;
        fwd_sel_p1  <= sel_onehot(mode_q);
      end
    end
  end

  assign o_mode    = mode_q;
  assign o_sel     = fwd_sel_p1;
  assign o_rx_data = fwd_data_p1;
  assign o_rx_done = vld_p1;

  // Commands are acknowledged with the resulting mode digit, data bytes are echoed
  assign ack_push = rx_done;
  assign ack_data = is_cmd ? mode_ascii(mode_nxt) : rx_data;

  ack_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (ACK_DEPTH)
  ) u_ack_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ack_push),
    .push_data (ack_data),
    .pop       (ack_pop),
    .head      (ack_head),
    .full      (ack_full),
    .empty     (ack_empty)
  );

  // Sticky overflow: a push into a full FIFO with no pop is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             ovf_q <= 1'b0;
    else if (ack_push && ack_full && !ack_pop) ovf_q <= 1'b1;
  end

  assign o_ack_ovf = ovf_q;

  // TX sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      lcnt_q  <= lcnt_nxt;
    end
  end

  // TX sequencer next state: pop in IDLE, wait for busy in LAUNCH (bounded), wait for idle in DRAIN
  always_comb begin
    state_nxt = state_q;
    lcnt_nxt  = lcnt_q;
    ack_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ack_empty && !tx_busy) begin
          ack_pop   = 1'b1;
          state_nxt = LAUNCH;
          lcnt_nxt  = '0;
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          state_nxt = DRAIN;
        end else if (lcnt_q == LAUNCH_LAST) begin
          state_nxt = IDLE;
        end else begin
          lcnt_nxt = lcnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transmit request is a one-cycle pulse carrying the popped head byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= ack_pop;
      if (ack_pop) tx_data <= ack_head;
    end
  end

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Directed bench for uart_cmd_dispatcher with a simple UART TX busy model.
module tb_uart_cmd_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       btn_mode;
  logic       tx_busy;
  logic [1:0] o_mode;
  logic [3:0] o_sel;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       o_ack_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  // 0: busy for 10 cycles per start, 1: held high, 2: never rises
  int busy_mode = 0;
  int busy_cnt  = 0;
  logic [7:0] sent [$];

  uart_cmd_dispatcher dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .btn_mode  (btn_mode),
    .tx_busy   (tx_busy),
    .o_mode    (o_mode),
    .o_sel     (o_sel),
    .o_rx_data (o_rx_data),
    .o_rx_done (o_rx_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .o_ack_ovf (o_ack_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] sent_at(input int i);
    if (i < sent.size()) return {24'd0, sent[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_btn(input logic [7:0] b);
    rx_data  = b;
    rx_done  = 1'b1;
    btn_mode = 1'b1;
    @(negedge clk);
    rx_done  = 1'b0;
    btn_mode = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},  o_mode,    0);
    check({tag, "_sel"},   o_sel,     4'b0001);
    check({tag, "_data"},  o_rx_data, 0);
    check({tag, "_done"},  o_rx_done, 0);
    check({tag, "_start"}, tx_start,  0);
    check({tag, "_txd"},   tx_data,   0);
    check({tag, "_ovf"},   o_ack_ovf, 0);
  endtask

  // UART TX model: records every transmit request and drives tx_busy
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
        tx_busy  = 1'b0;
      end else begin
        if (tx_start) begin
          sent.push_back(tx_data);
          if (busy_mode == 0) busy_cnt = 10;
        end
        if (busy_mode == 1) tx_busy = 1'b1;
        else if (busy_mode == 2) tx_busy = 1'b0;
        else if (busy_cnt > 0) begin
          tx_busy = 1'b1;
          busy_cnt--;
        end else tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rx_data  = 8'h00;
    rx_done  = 1'b0;
    btn_mode = 1'b0;
    tick(3);
    check_reset_vals("rst");
    rst = 1'b1;
    tick(1);

    // Plain byte at mode 0: forwarded next cycle, echoed two cycles later
    send(8'h47);
    check("fwd_done", o_rx_done, 1);
    check("fwd_data", o_rx_data, 8'h47);
    check("fwd_sel",  o_sel,     4'b0001);
    check("fwd_nostart", tx_start, 0);
    tick(1);
    check("ack_start", tx_start, 1);
    check("ack_data",  tx_data,  8'h47);
    check("fwd_pulse", o_rx_done, 0);
    tick(20);
    sent.delete();

    // Four 'M' commands step the mode and are never forwarded
    for (int i = 0; i < 4; i++) begin
      send(8'h4D);
      check("m_mode",  o_mode,    (i + 1) % 4);
      check("m_nofwd", o_rx_done, 0);
    end
    tick(70);
    check("m_ack_cnt", sent.size(), 4);
    check("m_ack0", sent_at(0), 8'h31);
    check("m_ack1", sent_at(1), 8'h32);
    check("m_ack2", sent_at(2), 8'h33);
    check("m_ack3", sent_at(3), 8'h30);
    sent.delete();

    // Button with a data byte at mode 1: select uses the old mode
    send(8'h4D);
    send_btn(8'h53);
    check("btn_sel",  o_sel,     4'b0010);
    check("btn_data", o_rx_data, 8'h53);
    check("btn_done", o_rx_done, 1);
    check("btn_mode", o_mode,    2);
    tick(30);

    // Button together with 'M' steps once; with 'W' goes home
    send(8'h57);
    check("w_mode", o_mode, 0);
    send_btn(8'h4D);
    check("btnm_mode",  o_mode,    1);
    check("btnm_nofwd", o_rx_done, 0);
    send_btn(8'h57);
    check("btnw_mode", o_mode, 0);
    tick(90);
    check("mix_cnt", sent.size(), 5);
    check("mix0", sent_at(0), 8'h31);
    check("mix1", sent_at(1), 8'h53);
    check("mix2", sent_at(2), 8'h30);
    check("mix3", sent_at(3), 8'h31);
    check("mix4", sent_at(4), 8'h30);
    sent.delete();

    // Overflow: transmitter stalled, six echoes, only four kept
    busy_mode = 1;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      send(8'hA0 + 8'(i));
      if (i == 3) check("ovf_clear", o_ack_ovf, 0);
      if (i == 4) check("ovf_set",   o_ack_ovf, 1);
    end
    busy_mode = 0;
    tick(80);
    check("ovf_cnt", sent.size(), 4);
    for (int i = 0; i < 4; i++) check("ovf_byte", sent_at(i), 8'hA0 + i);
    check("ovf_sticky", o_ack_ovf, 1);
    sent.delete();

    // Button alone steps the mode
    btn_mode = 1'b1;
    tick(1);
    btn_mode = 1'b0;
    check("btn_only", o_mode, 1);

    // LAUNCH timeout: busy never rises, next byte goes out 5 cycles later
    busy_mode = 2;
    tick(2);
    send(8'hB1);
    send(8'hB2);
    check("to_start1", tx_start, 1);
    check("to_data1",  tx_data,  8'hB1);
    tick(3);
    check("to_wait", tx_start, 0);
    tick(1);
    check("to_wait2", tx_start, 0);
    busy_mode = 0;
    tick(1);
    check("to_start2", tx_start, 1);
    check("to_data2",  tx_data,  8'hB2);

    // Reset in DRAIN with a byte still queued
    send(8'hC0);
    check("pre_rst_data", o_rx_data, 8'hC0);
    check("pre_rst_sel",  o_sel,     4'b0010);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("arst");
    @(negedge clk);
    rst = 1'b1;
    n0 = sent.size();
    tick(20);
    check("rst_fifo_empty", sent.size(), n0);
    check("rst_idle", tx_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
